pdw_snapshot_rx: RTL and testbench
==================================

PDW_SNAPSHOT_RX -- requirements
Module: pdw_snapshot_rx

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16, bits per sample word.
REQ-002 SHALL have parameter NUM_TAPS, default 10, samples per snapshot.
REQ-003 SHALL have parameter ABS_TIME_WIDTH, default 32, timestamp bits.
REQ-004 SHALL derive FRAME_BITS = SAMPLE_WIDTH*NUM_TAPS + ABS_TIME_WIDTH (192) and NUM_WORDS = FRAME_BITS/16 (12).
REQ-005 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port: rst  in  1  synchronous, active-low reset.
REQ-007 SHALL have port: pdw_data  in  1  serial snapshot bit, MSB first.
REQ-008 SHALL have port: pdw_frame  in  1  high for exactly the bits of one frame.
REQ-009 SHALL have port: word_data  out  16  output word.
REQ-010 SHALL have port: word_valid  out  1  word_data valid.
REQ-011 SHALL have port: word_ready  in  1  downstream accepts word.
REQ-012 SHALL have port: word_first / word_last  out  1 each  first/last word of a frame.
REQ-013 SHALL have port: frame_err  out  1  one-cycle pulse on a rejected frame.
REQ-014 SHALL have port: drop_cnt  out  8  saturating count of good frames dropped on overrun.

Function
REQ-015 SHALL sample pdw_data once per cycle while pdw_frame=1, shifting into an FRAME_BITS shift register; first bit lands in bit FRAME_BITS-1.
REQ-016 SHALL run FSM IDLE->RECV on pdw_frame 0->1 (previous sampled value 0); RECV->CHECK on first cycle pdw_frame=0; CHECK->IDLE after one cycle.
REQ-017 SHALL count received bits in RECV with a counter saturating at FRAME_BITS+1; CHECK accepts only when count == FRAME_BITS.
REQ-018 SHALL, in CHECK with a bad length, pulse frame_err for one cycle and discard the frame.
REQ-019 SHALL, in CHECK with a good frame and output buffer empty, copy the shift register to the output buffer; word_valid rises the cycle after CHECK.
REQ-020 SHALL, in CHECK with a good frame and output buffer still streaming, drop the new frame, increment drop_cnt (saturate at 255), and not assert frame_err.
REQ-021 SHALL emit NUM_WORDS words: word 0 = buffer bits [FRAME_BITS-1 -: 16] (sample NUM_TAPS-1) through the last word = timestamp[15:0].
REQ-022 SHALL hold word_data/word_valid/flags stable until word_valid & word_ready; advance one word per handshake; allow one word per cycle.
REQ-023 SHALL assert word_first with word 0 only, and word_last with word NUM_WORDS-1 only; buffer becomes empty in the cycle the last word handshakes.
REQ-024 SHALL permit a frame finishing CHECK in the same cycle the last word handshakes to be accepted (no drop).
REQ-025 SHALL accept back-to-back frames separated by one pdw_frame=0 cycle.

Reset
REQ-026 SHALL on rst=0: FSM=IDLE, bit count=0, previous pdw_frame register=1, word_valid=0, word_first=0, word_last=0, frame_err=0, drop_cnt=0, word_data=0.
REQ-027 SHALL discard a partial frame when reset is asserted mid-frame; a frame already high at reset release SHALL be ignored until pdw_frame returns to 0.

Configuration
REQ-028 SHALL, with PDW_RX_CRC_EN defined, expect 16 extra trailing bits (CRC-16/CCITT, poly 0x1021, init 0xFFFF, over the FRAME_BITS MSB first); a length of FRAME_BITS+16 is required, and a CRC mismatch causes frame_err and discard.
REQ-029 SHALL, without PDW_RX_CRC_EN, have no CRC logic, and a frame of FRAME_BITS+16 bits SHALL be a length error.

Structure
REQ-030 SHALL place FRAME_BITS/NUM_WORDS derivation, FSM state encoding and CRC poly/init constants in shared package pdw_pkg.
REQ-031 SHALL implement the CRC as sub-module crc16_ccitt_serial (one bit per cycle, clear, enable), instantiated only under PDW_RX_CRC_EN.

Verification
REQ-032 Send one 192-bit frame, timestamp 0x0000_1234, samples 9..0 = 0x0009..0x0000, word_ready=1 -> 12 words 0x0009..0x0000, 0x0000, 0x1234; first/last flags correct; word_valid rises the cycle after CHECK.
REQ-033 Send a 191-bit frame and then a 193-bit frame -> two frame_err pulses, no word_valid, drop_cnt=0.
REQ-034 Hold word_ready=0 and send two good frames -> first buffered, second dropped, drop_cnt=1; release ready -> only the first frame's 12 words appear.
REQ-035 Assert rst for 1 cycle at bit 100, release with pdw_frame still high -> no output or error from that frame; next clean frame is received correctly.
REQ-036 Toggle word_ready randomly at 50% -> data is stable while stalled and all 12 words arrive in order.
REQ-037 With PDW_RX_CRC_EN: a correct CRC produces 12 words; flipping bit 7 of the payload produces frame_err and no words.

Source files
------------

// File: rtl/pdw_pkg.sv
// Shared definitions for the PDW snapshot receiver: frame sizing helpers,
// receive FSM encoding and CRC-16/CCITT constants.
package pdw_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int CRC_WIDTH  = 16;
    localparam logic [CRC_WIDTH-1:0] CRC_POLY = 16'h1021;
    localparam logic [CRC_WIDTH-1:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } rx_state_t;

    function automatic int frame_bits(input int sample_width, input int num_taps,
                                      input int abs_time_width);
        return sample_width * num_taps + abs_time_width;
    endfunction

    function automatic int num_words(input int fbits);
        return fbits / WORD_WIDTH;
    endfunction

    function automatic logic [CRC_WIDTH-1:0] crc16_step(input logic [CRC_WIDTH-1:0] crc,
                                                       input logic bit_in);
        logic fb;
        fb = crc[CRC_WIDTH-1] ^ bit_in;
        return {crc[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    endfunction

endpackage

// File: rtl/crc16_ccitt_serial.sv
// Bit-serial CRC-16/CCITT (poly 0x1021, init 0xFFFF), MSB first. A clear in the
// same cycle as enable seeds the new frame with its first bit already folded in.
module crc16_ccitt_serial
    import pdw_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic                 data,
    output logic [CRC_WIDTH-1:0] crc
);

    logic [CRC_WIDTH-1:0] seed;

    assign seed = clear ? CRC_INIT : crc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            crc <= CRC_INIT;
        end else if (enable) begin
            crc <= crc16_step(seed, data);
        end else if (clear) begin
            crc <= CRC_INIT;
        end
    end

endmodule

// File: rtl/pdw_snapshot_rx.sv
// Serial PDW snapshot receiver: captures one framed bit-serial snapshot, checks its
// length (and CRC when PDW_RX_CRC_EN is defined), then streams it out as 16-bit words.
module pdw_snapshot_rx
    import pdw_pkg::*;
#(
    parameter int SAMPLE_WIDTH   = 16,
    parameter int NUM_TAPS       = 10,
    parameter int ABS_TIME_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pdw_data,
    input  logic        pdw_frame,
    output logic [15:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        word_first,
    output logic        word_last,
    output logic        frame_err,
    output logic [7:0]  drop_cnt
);

    localparam int FRAME_BITS = frame_bits(SAMPLE_WIDTH, NUM_TAPS, ABS_TIME_WIDTH);
    localparam int NUM_WORDS  = num_words(FRAME_BITS);
`ifdef PDW_RX_CRC_EN
    localparam int EXP_BITS   = FRAME_BITS + CRC_WIDTH;
`else
    localparam int EXP_BITS   = FRAME_BITS;
`endif
    localparam int CNT_W      = $clog2(EXP_BITS + 2);
    localparam int IDX_W      = $clog2(NUM_WORDS + 1);

    rx_state_t             state, state_nxt;
    logic                  frame_prev;
    logic [CNT_W-1:0]      bit_cnt, eff_cnt;
    logic [FRAME_BITS-1:0] shreg, out_buf;
    logic [IDX_W-1:0]      word_idx;
    logic                  starting, capture, payload_bit;
    logic                  len_ok, crc_ok, frame_good, last_hs, buf_free;

    // A new frame may start straight out of CHECK so a one-cycle gap is enough.
    assign starting    = pdw_frame && !frame_prev && (state != ST_RECV);
    assign capture     = starting || ((state == ST_RECV) && pdw_frame);
    assign eff_cnt     = starting ? '0 : bit_cnt;
    assign payload_bit = eff_cnt < CNT_W'(FRAME_BITS);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (starting) state_nxt = ST_RECV;
            ST_RECV:  if (!pdw_frame) state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = starting ? ST_RECV : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: frame_prev resets high so a frame already in flight is ignored.
            frame_prev <= 1'b1;
            bit_cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from old values.
            frame_prev <= pdw_frame;
            if (starting) begin
                bit_cnt <= CNT_W'(1);
            end else if ((state == ST_RECV) && pdw_frame && (bit_cnt != CNT_W'(EXP_BITS + 1))) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    // NOTE: the capture shift register is pure datapath and carries no reset.
    always_ff @(posedge clk) begin
        if (capture && payload_bit) begin
            shreg <= {shreg[FRAME_BITS-2:0], pdw_data};
        end
    end

`ifdef PDW_RX_CRC_EN
    logic [CRC_WIDTH-1:0] crc_calc, crc_rx;

    crc16_ccitt_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .clear  (starting),
        .enable (capture && payload_bit),
        .data   (pdw_data),
        .crc    (crc_calc)
    );

    always_ff @(posedge clk) begin
        if (capture && !payload_bit) begin
            crc_rx <= {crc_rx[CRC_WIDTH-2:0], pdw_data};
        end
    end

    assign crc_ok = (crc_calc == crc_rx);
`else
    assign crc_ok = 1'b1;
`endif

    assign len_ok     = (bit_cnt == CNT_W'(EXP_BITS));
    assign frame_good = len_ok && crc_ok;
    assign last_hs    = word_valid && word_ready && (word_idx == IDX_W'(NUM_WORDS - 1));
    assign buf_free   = !word_valid || last_hs;

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_buf    <= '0;
            word_valid <= 1'b0;
            word_idx   <= '0;
            frame_err  <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            frame_err <= (state == ST_CHECK) && !frame_good;
            if ((state == ST_CHECK) && frame_good && buf_free) begin
                out_buf    <= shreg;
                word_valid <= 1'b1;
                word_idx   <= '0;
            end else if (word_valid && word_ready) begin
                if (last_hs) begin
                    word_valid <= 1'b0;
                end else begin
                    out_buf  <= {out_buf[FRAME_BITS-WORD_WIDTH-1:0], WORD_WIDTH'(0)};
                    word_idx <= word_idx + IDX_W'(1);
                end
            end
            if ((state == ST_CHECK) && frame_good && !buf_free && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    assign word_data  = out_buf[FRAME_BITS-1 -: WORD_WIDTH];
    assign word_first = word_valid && (word_idx == '0);
    assign word_last  = word_valid && (word_idx == IDX_W'(NUM_WORDS - 1));

endmodule

// File: tb/tb_pdw_snapshot_rx.sv
// Directed/randomized bench for pdw_snapshot_rx; a frame-level model predicts the
// word stream, error pulses and drop count. Honours PDW_RX_CRC_EN like the RTL.
module tb_pdw_snapshot_rx;

    localparam int FB = 192;
    localparam int NW = 12;
`ifdef PDW_RX_CRC_EN
    localparam int EXP_LEN = FB + 16;
`else
    localparam int EXP_LEN = FB;
`endif

    typedef struct packed {
        logic [15:0] data;
        logic        first;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pdw_data = 1'b0;
    logic        pdw_frame = 1'b0;
    logic        word_ready = 1'b0;
    logic [15:0] word_data;
    logic        word_valid, word_first, word_last, frame_err;
    logic [7:0]  drop_cnt;

    pdw_snapshot_rx dut (
        .clk        (clk),
        .rst        (rst),
        .pdw_data   (pdw_data),
        .pdw_frame  (pdw_frame),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_first (word_first),
        .word_last  (word_last),
        .frame_err  (frame_err),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int          compared = 0;
    int          mismatched = 0;
    int          err_seen = 0;
    int          exp_err = 0;
    int          exp_drop = 0;
    word_t       exp_q[$];
    bit          rand_ready = 1'b0;
    int          pend_stage = 0;
    logic [FB-1:0] pend_payload;
    bit          pend_good;
    bit          hold_chk = 1'b0;
    word_t       held, mon_e;
    logic [255:0] vec;
    logic [FB-1:0] pay;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifdef PDW_RX_CRC_EN
    function automatic logic [15:0] ref_crc(input logic [FB-1:0] p);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = FB - 1; i >= 0; i--) begin
            c = (c[15] ^ p[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction
`endif

    function automatic logic [255:0] wrap(input logic [FB-1:0] p);
`ifdef PDW_RX_CRC_EN
        return {48'b0, p, ref_crc(p)};
`else
        return {64'b0, p};
`endif
    endfunction

    function automatic logic [FB-1:0] rand_payload();
        logic [FB-1:0] p;
        for (int i = 0; i < FB / 32; i++) p[32*i +: 32] = $urandom();
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) word_ready = ($urandom_range(0, 1) == 1);
    endtask

    // Frame-level decision: bad frames error, good frames land if the output
    // buffer is empty or draining its last word in the CHECK cycle, else drop.
    task automatic decide();
        word_t e;
        if (!pend_good) begin
            exp_err++;
        end else if (exp_q.size() == 0 || (exp_q.size() == 1 && word_ready)) begin
            for (int w = 0; w < NW; w++) begin
                e.data  = pend_payload[FB-1-16*w -: 16];
                e.first = (w == 0);
                e.last  = (w == NW - 1);
                exp_q.push_back(e);
            end
        end else if (exp_drop < 255) begin
            exp_drop++;
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (pend_stage == 2) begin
            pend_stage = 0;
            decide();
        end else if (pend_stage == 1) begin
            pend_stage = 2;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            hold_chk = 1'b0;
        end else begin
            if (frame_err) err_seen++;
            if (hold_chk) begin
                check("stall_valid", 32'(word_valid), 32'd1);
                check("stall_data", 32'(word_data), 32'(held.data));
                check("stall_flags", 32'({word_first, word_last}), 32'({held.first, held.last}));
            end
            hold_chk = word_valid && !word_ready;
            held = {word_data, word_first, word_last};
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(word_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("word_data", 32'(word_data), 32'(mon_e.data));
                    check("word_first", 32'(word_first), 32'(mon_e.first));
                    check("word_last", 32'(word_last), 32'(mon_e.last));
                end
            end
        end
    end

    task automatic send_frame(input logic [255:0] v, input int len, input int ready_at);
        for (int i = 0; i < len; i++) begin
            tick();
            pdw_frame = 1'b1;
            pdw_data  = v[len-1-i];
            if (i == ready_at) word_ready = 1'b1;
        end
        tick();
        pdw_frame = 1'b0;
        pdw_data  = 1'b0;
        pend_payload = (len >= FB) ? v[len-1 -: FB] : '0;
`ifdef PDW_RX_CRC_EN
        pend_good = (len == EXP_LEN) && (v[15:0] == ref_crc(pend_payload));
`else
        pend_good = (len == EXP_LEN);
`endif
        pend_stage = 1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || word_valid || pend_stage != 0) && n < 600) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check({tag, "_timeout"}, 32'(n < 600), 32'd1);
        check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_err_cnt"}, 32'(err_seen), 32'(exp_err));
        check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_first", 32'(word_first), 32'd0);
        check("rst_last", 32'(word_last), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_data", 32'(word_data), 32'd0);
        rst = 1'b1;
        repeat (2) tick();

        // Known frame: samples 9..0 = 9..0, timestamp 0x1234
        word_ready = 1'b1;
        pay[31:0] = 32'h0000_1234;
        for (int s = 0; s < 10; s++) pay[32+16*s +: 16] = 16'(s);
        send_frame(wrap(pay), EXP_LEN, -1);
        tick();
        check("valid_in_check", 32'(word_valid), 32'd0);
        tick();
        check("valid_after_check", 32'(word_valid), 32'd1);
        check("word0_value", 32'(word_data), 32'h0009);
        drain("known");

        // Length errors: short, long, and payload plus 16 trailing bits
        send_frame(wrap(rand_payload()), EXP_LEN - 1, -1);
        send_frame(wrap(rand_payload()), EXP_LEN + 1, -1);
        send_frame(wrap(rand_payload()), FB + 16, -1);
        drain("length");
        check("length_no_valid", 32'(word_valid), 32'd0);

        // Overrun: ready low, two frames; then a third whose CHECK meets the last handshake
        word_ready = 1'b0;
        send_frame(wrap(rand_payload()), EXP_LEN, -1);
        send_frame(wrap(rand_payload()), EXP_LEN, -1);
        repeat (3) tick();
        check("overrun_drop", 32'(drop_cnt), 32'(exp_drop));
        check("overrun_held_valid", 32'(word_valid), 32'd1);
        check("overrun_held_first", 32'(word_first), 32'd1);
        send_frame(wrap(rand_payload()), EXP_LEN, EXP_LEN - 10);
        word_ready = 1'b1;
        drain("overrun");

        // Reset pulse at bit 100 with the frame still high afterwards
        vec = wrap(rand_payload());
        for (int i = 0; i < EXP_LEN; i++) begin
            tick();
            pdw_frame = 1'b1;
            pdw_data  = vec[EXP_LEN-1-i];
            if (i == 100) rst = 1'b0;
            if (i == 101) rst = 1'b1;
        end
        tick();
        pdw_frame = 1'b0;
        exp_drop = 0;
        repeat (4) tick();
        check("midrst_no_valid", 32'(word_valid), 32'd0);
        check("midrst_drop_clear", 32'(drop_cnt), 32'(exp_drop));
        check("midrst_err", 32'(err_seen), 32'(exp_err));
        send_frame(wrap(rand_payload()), EXP_LEN, -1);
        drain("post_rst");

        // Random ready, back-to-back frames
        rand_ready = 1'b1;
        for (int f = 0; f < 3; f++) send_frame(wrap(rand_payload()), EXP_LEN, -1);
        drain("rand_ready");
        rand_ready = 1'b0;
        word_ready = 1'b1;

`ifdef PDW_RX_CRC_EN
        send_frame(wrap(rand_payload()), EXP_LEN, -1);
        drain("crc_good");
        vec = wrap(rand_payload());
        vec[7+16] = ~vec[7+16];
        send_frame(vec, EXP_LEN, -1);
        drain("crc_bad");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
